// File: rtl/fir_pkg.sv
// Shared sizing helpers and sample type for the moving-average FIR audio filter.
package fir_pkg;

    localparam int SAMPLE_W = 24;

    // Default audio sample type; modules built at other widths declare their own.
    typedef logic signed [SAMPLE_W-1:0] sample_t;

    function automatic int acc_width(input int data_w, input int log2_taps);
        return data_w + log2_taps;
    endfunction

    function automatic int taps(input int log2_taps);
        return 1 << log2_taps;
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Circular TAPS-entry sample history; the entry at the write pointer is the oldest sample.
module fir_delay_line
    import fir_pkg::*;
#(
    parameter int DATA_W    = 24,
    parameter int LOG2_TAPS = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic                     clr,
    input  logic signed [DATA_W-1:0] din,
    output logic signed [DATA_W-1:0] oldest
);

    localparam int TAPS = taps(LOG2_TAPS);

    logic signed [DATA_W-1:0] hist [TAPS];
    logic [LOG2_TAPS-1:0]     wp;

    // Read before the write on the same edge, so the evicted sample feeds the running sum.
    assign oldest = hist[wp];

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            for (int i = 0; i < TAPS; i++) begin
                hist[i] <= '0;
            end
            wp <= '0;
        end else if (wr_en) begin
            hist[wp] <= din;
            wp       <= wp + 1'b1;
        end
    end

endmodule

// File: rtl/fir_avg_stream.sv
// Strobed moving-average FIR: running sum over TAPS samples, one shift-divide at the output.
// Optional build macro FIR_AVG_ROUND_EN selects round-half-up instead of floor.
module fir_avg_stream
    import fir_pkg::*;
#(
    parameter int DATA_W    = 24,
    parameter int LOG2_TAPS = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in,
    input  logic                     clear,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out,
    output logic                     primed
);

    localparam int TAPS  = taps(LOG2_TAPS);
    localparam int ACC_W = acc_width(DATA_W, LOG2_TAPS);
    localparam int CNT_W = LOG2_TAPS + 1;

    logic signed [DATA_W-1:0] oldest;
    logic signed [ACC_W-1:0]  acc_nxt;

    logic signed [ACC_W-1:0]  acc_p0;
    logic [CNT_W-1:0]         cnt_p0;
    logic                     vld_p0;

    logic signed [DATA_W-1:0] out_p1;
    logic                     vld_p1;
    logic                     primed_p1;

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [DATA_W-1:0] x);
        return $signed({{LOG2_TAPS{x[DATA_W-1]}}, x});
    endfunction

`ifdef FIR_AVG_ROUND_EN
    localparam int HALF = 1 << (LOG2_TAPS - 1);

    // Extra bit keeps the rounding bias from wrapping a full-scale positive sum.
    function automatic logic signed [DATA_W-1:0] scale(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W:0] r;
        r = {a[ACC_W-1], a} + (ACC_W+1)'(HALF);
        return DATA_W'(r >>> LOG2_TAPS);
    endfunction
`else
    function automatic logic signed [DATA_W-1:0] scale(input logic signed [ACC_W-1:0] a);
        return DATA_W'(a >>> LOG2_TAPS);
    endfunction
`endif

    fir_delay_line #(
        .DATA_W    (DATA_W),
        .LOG2_TAPS (LOG2_TAPS)
    ) u_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (in_valid),
        .clr    (clear),
        .din    (in),
        .oldest (oldest)
    );

    assign acc_nxt = acc_p0 + sext(in) - sext(oldest);

    // Stage p0: accept edge -- running sum, fill count and result-pending flag.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            acc_p0 <= '0;
            cnt_p0 <= '0;
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= in_valid;
            if (in_valid) begin
                acc_p0 <= acc_nxt;
                if (cnt_p0 != CNT_W'(TAPS)) begin
                    cnt_p0 <= cnt_p0 + 1'b1;
                end
            end
        end
    end

    // Stage p1: divide the updated sum and publish; clear leaves the last result visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_p1    <= '0;
            vld_p1    <= 1'b0;
            primed_p1 <= 1'b0;
        end else if (clear) begin
            vld_p1    <= 1'b0;
            primed_p1 <= 1'b0;
        end else begin
            vld_p1    <= vld_p0;
            primed_p1 <= (cnt_p0 == CNT_W'(TAPS));
            if (vld_p0) begin
                out_p1 <= scale(acc_p0);
            end
        end
    end

    assign out       = out_p1;
    assign out_valid = vld_p1;
    assign primed    = primed_p1;

endmodule

// File: tb/tb_fir_avg_stream.sv
// Self-checking bench for fir_avg_stream: directed scenarios plus random traffic against a sample-window model.
module tb_fir_avg_stream;

    localparam int DATA_W    = 24;
    localparam int LOG2_TAPS = 3;
    localparam int TAPS      = 8;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in;
    logic                     clear;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out;
    logic                     primed;

    fir_avg_stream #(
        .DATA_W    (DATA_W),
        .LOG2_TAPS (LOG2_TAPS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in        (in),
        .clear     (clear),
        .out_valid (out_valid),
        .out       (out),
        .primed    (primed)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: window of the last TAPS accepted samples (zeros before fill).
    longint hq[$];
    int     nacc;
    bit     pend;
    longint pend_val;
    bit     prim_due;
    bit     e_vld;
    longint e_out;
    bit     e_primed;

`ifdef FIR_AVG_ROUND_EN
    longint const3_tbl[8] = '{0, 1, 1, 2, 2, 2, 3, 3};
`else
    longint const3_tbl[8] = '{0, 0, 1, 1, 1, 2, 2, 3};
`endif

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint floor_div(input longint s);
        if (s >= 0) return s / TAPS;
        return -((-s + TAPS - 1) / TAPS);
    endfunction

    function automatic longint mean_of_window();
        longint sum = 0;
        foreach (hq[i]) sum += hq[i];
`ifdef FIR_AVG_ROUND_EN
        return floor_div(sum + TAPS / 2);
`else
        return floor_div(sum);
`endif
    endfunction

    task automatic flush_window();
        hq.delete();
        for (int i = 0; i < TAPS; i++) hq.push_back(0);
        nacc     = 0;
        pend     = 1'b0;
        prim_due = 1'b0;
    endtask

    task automatic model_edge(input bit v, input longint s, input bit c, input bit r);
        if (!r) begin
            flush_window();
            e_vld    = 1'b0;
            e_out    = 0;
            e_primed = 1'b0;
        end else if (c) begin
            flush_window();
            e_vld    = 1'b0;
            e_primed = 1'b0;
        end else begin
            e_vld    = pend;
            if (pend) e_out = pend_val;
            e_primed = prim_due;
            if (v) begin
                hq.push_back(s);
                void'(hq.pop_front());
                if (nacc < TAPS) nacc++;
                pend     = 1'b1;
                pend_val = mean_of_window();
            end else begin
                pend = 1'b0;
            end
            prim_due = (nacc >= TAPS);
        end
    endtask

    task automatic cyc(input bit v, input longint d, input bit c, input bit r);
        logic signed [DATA_W-1:0] s;
        s        = d[DATA_W-1:0];
        in_valid = v;
        in       = s;
        clear    = c;
        rst_n    = r;
        @(posedge clk);
        model_edge(v, longint'(s), c, r);
        @(negedge clk);
        check("out_valid", longint'(out_valid), longint'(e_vld));
        check("out", longint'(out), e_out);
        check("primed", longint'(primed), longint'(e_primed));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, 1'b1);
    endtask

    initial begin
        in_valid = 1'b0;
        in       = '0;
        clear    = 1'b0;
        rst_n    = 1'b0;
        flush_window();
        e_vld = 1'b0; e_out = 0; e_primed = 1'b0;

        cyc(1'b0, 0, 1'b0, 1'b0);
        cyc(1'b1, 123, 1'b0, 1'b0);
        check("reset_out", longint'(out), 0);
        check("reset_primed", longint'(primed), 0);
        idle(2);

        // Impulse response
        cyc(1'b1, 800, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) cyc(1'b1, 0, 1'b0, 1'b1);
        cyc(1'b1, 0, 1'b0, 1'b1);
        check("impulse_8th", longint'(out), 100);
        check("impulse_primed", longint'(primed), 1);
        idle(1);
        check("impulse_tail", longint'(out), 0);

        // Step down and back
        for (int i = 0; i < 8; i++) cyc(1'b1, -8, 1'b0, 1'b1);
        idle(1);
        check("step_floor", longint'(out), -8);
        for (int i = 0; i < 8; i++) cyc(1'b1, 0, 1'b0, 1'b1);
        idle(1);
        check("step_back", longint'(out), 0);

        // Constant 3 ramp, exposes floor vs rounding
        cyc(1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 3, 1'b0, 1'b1);
            cyc(1'b0, 0, 1'b0, 1'b1);
            check("const3", longint'(out), const3_tbl[i]);
        end

        // Full-scale extremes with idle gaps
        cyc(1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 8388607, 1'b0, 1'b1);
            idle(int'($urandom_range(0, 5)));
        end
        idle(1);
        check("max_end", longint'(out), 8388607);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, -8388608, 1'b0, 1'b1);
            idle(int'($urandom_range(0, 5)));
        end
        idle(1);
        check("min_end", longint'(out), -8388608);

        // Clear beats a simultaneous sample
        for (int i = 0; i < 8; i++) cyc(1'b1, 1000, 1'b0, 1'b1);
        idle(2);
        check("clr_primed_before", longint'(primed), 1);
        cyc(1'b1, 5000, 1'b1, 1'b1);
        check("clr_vld", longint'(out_valid), 0);
        check("clr_primed", longint'(primed), 0);
        check("clr_out_hold", longint'(out), 1000);
        cyc(1'b1, 80, 1'b0, 1'b1);
        idle(1);
        check("clr_next", longint'(out), 10);

        // Reset mid-stream beats a simultaneous sample
        for (int i = 0; i < 8; i++) cyc(1'b1, 1000, 1'b0, 1'b1);
        idle(2);
        cyc(1'b1, 5000, 1'b0, 1'b0);
        check("rst_out", longint'(out), 0);
        check("rst_primed", longint'(primed), 0);
        check("rst_vld", longint'(out_valid), 0);
        cyc(1'b1, 16, 1'b0, 1'b1);
        check("rst_vld_after", longint'(out_valid), 0);
        idle(1);
        check("rst_next", longint'(out), 2);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic signed [DATA_W-1:0] rs;
            int roll;
            rs   = DATA_W'($urandom);
            roll = int'($urandom_range(0, 199));
            cyc(($urandom_range(0, 1) == 1), longint'(rs), (roll < 3), (roll != 199));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
